// File: rtl/mem_copy_dma_pkg.sv
// Shared definitions for the mem_copy_dma word-copy engine: FSM encoding,
// bus constants and the word-alignment helper.
package mem_copy_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_REQ = 3'd1,
    ST_RD_RSP = 3'd2,
    ST_WR_REQ = 3'd3,
    ST_WR_RSP = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam logic [3:0]  SEL_WORD  = 4'hF;
  localparam logic [31:0] ADDR_STEP = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_copy_dma.sv
// Single-channel word-copy DMA master on the valid/ready memory bus.
// Optional sticky completion interrupt: define MEM_COPY_DMA_IRQ_EN.
module mem_copy_dma
  import mem_copy_dma_pkg::*;
#(
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [31:0]      src_addr_i,
  input  logic [31:0]      dst_addr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             irq_o,
  output logic [31:0]      addr_o,
  output logic [31:0]      data_o,
  output logic [3:0]       sel_o,
  output logic             we_o,
  output logic             req_valid_o,
  input  logic             req_ready_i,
  input  logic [31:0]      data_i,
  input  logic             rsp_valid_i,
  output logic             rsp_ready_o
);

  state_t           state;
  logic [31:0]      src;
  logic [31:0]      dst;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] cnt_nxt;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{src_addr_i[1:0], dst_addr_i[1:0]};

  always_comb begin
    cnt_nxt = cnt + LEN_W'(1);
  end

  // Outputs are loaded together with the state transition so each one is a
  // registered decode of the state being entered; data_o doubles as the word buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      src         <= '0;
      dst         <= '0;
      len         <= '0;
      cnt         <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      addr_o      <= '0;
      data_o      <= '0;
      sel_o       <= '0;
      we_o        <= 1'b0;
      req_valid_o <= 1'b0;
      rsp_ready_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            src    <= word_align(src_addr_i);
            dst    <= word_align(dst_addr_i);
            len    <= len_i;
            cnt    <= '0;
            busy_o <= 1'b1;
            if (len_i == '0) begin
              state  <= ST_DONE;
              done_o <= 1'b1;
            end else begin
              state       <= ST_RD_REQ;
              req_valid_o <= 1'b1;
              we_o        <= 1'b0;
              sel_o       <= '0;
              addr_o      <= word_align(src_addr_i);
            end
          end
        end
        ST_RD_REQ: begin
          if (req_ready_i) begin
            state       <= ST_RD_RSP;
            req_valid_o <= 1'b0;
            rsp_ready_o <= 1'b1;
          end
        end
        ST_RD_RSP: begin
          if (rsp_valid_i) begin
            state       <= ST_WR_REQ;
            rsp_ready_o <= 1'b0;
            req_valid_o <= 1'b1;
            we_o        <= 1'b1;
            sel_o       <= SEL_WORD;
            addr_o      <= dst;
            data_o      <= data_i;
          end
        end
        ST_WR_REQ: begin
          if (req_ready_i) begin
            state       <= ST_WR_RSP;
            req_valid_o <= 1'b0;
            we_o        <= 1'b0;
            sel_o       <= '0;
            rsp_ready_o <= 1'b1;
          end
        end
        ST_WR_RSP: begin
          if (rsp_valid_i) begin
            cnt         <= cnt_nxt;
            src         <= src + ADDR_STEP;
            dst         <= dst + ADDR_STEP;
            rsp_ready_o <= 1'b0;
            if (cnt_nxt == len) begin
              state  <= ST_DONE;
              done_o <= 1'b1;
            end else begin
              state       <= ST_RD_REQ;
              req_valid_o <= 1'b1;
              addr_o      <= src + ADDR_STEP;
            end
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state       <= ST_IDLE;
          busy_o      <= 1'b0;
          req_valid_o <= 1'b0;
          rsp_ready_o <= 1'b0;
          we_o        <= 1'b0;
          sel_o       <= '0;
        end
      endcase
    end
  end

`ifdef MEM_COPY_DMA_IRQ_EN
  logic done_set;

  // Mirrors the two FSM paths that load done_o, so irq_o rises on the DONE cycle.
  always_comb begin
    done_set = ((state == ST_IDLE) && start_i && (len_i == '0)) ||
               ((state == ST_WR_RSP) && rsp_valid_i && (cnt_nxt == len));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_o <= 1'b0;
    end else if ((state == ST_IDLE) && start_i) begin
      irq_o <= done_set;
    end else if (done_set) begin
      irq_o <= 1'b1;
    end
  end
`else
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_copy_dma.sv
// Self-checking bench for mem_copy_dma: bus slave model with memory,
// write scoreboard, latency/stall/reset/wrap/irq scenarios.
module tb_mem_copy_dma;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [31:0] src_addr_i, dst_addr_i;
  logic [15:0] len_i;
  logic        busy_o, done_o, irq_o;
  logic [31:0] addr_o, data_o;
  logic [3:0]  sel_o;
  logic        we_o, req_valid_o, req_ready_i;
  logic [31:0] data_i;
  logic        rsp_valid_i, rsp_ready_o;

  mem_copy_dma #(.LEN_W(16)) dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .irq_o(irq_o),
    .addr_o(addr_o), .data_o(data_o), .sel_o(sel_o), .we_o(we_o),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
    .data_i(data_i), .rsp_valid_i(rsp_valid_i), .rsp_ready_o(rsp_ready_o)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] src_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] rd_addr_q[$];
  logic        we_log[$];

  int req_fire_cnt = 0, req_cycles = 0, busy_cycles = 0, done_cycles = 0;
  int wr_count = 0, reads_acc = 0;
  int stall_read = -1, stall_left = 0, stall_seen = 0;

  // Slave: zero-wait acceptance, response one cycle after acceptance,
  // optional stall on a chosen read. Drives on the falling edge.
  initial begin
    logic        req_f, rsp_f, f_we;
    logic [31:0] f_addr, f_data;
    logic [31:0] s_addr, s_data;
    logic [3:0]  s_sel;
    logic        s_we;
    wr_t         e;
    req_f = 1'b0; rsp_f = 1'b0; f_we = 1'b0; f_addr = '0; f_data = '0;
    s_addr = '0; s_data = '0; s_sel = '0; s_we = 1'b0;
    rsp_valid_i = 1'b0; data_i = '0; req_ready_i = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        req_f = 1'b0; rsp_f = 1'b0; rsp_valid_i = 1'b0; req_ready_i = 1'b1;
      end else begin
        if (rsp_f) rsp_valid_i = 1'b0;
        if (req_f) begin
          req_fire_cnt++;
          we_log.push_back(f_we);
          if (f_we) begin
            wr_count++;
            mem[f_addr] = f_data;
            data_i = 32'hDEAD_BEEF;
            tests++;
            if (exp_q.size() == 0) begin
              fails++;
              $display("FAIL sb_extra_write: got addr=%h data=%h, required no write", f_addr, f_data);
            end else begin
              e = exp_q.pop_front();
              if (f_addr !== e.addr || f_data !== e.data) begin
                fails++;
                $display("FAIL sb_write: got addr=%h data=%h, required addr=%h data=%h",
                         f_addr, f_data, e.addr, e.data);
              end
            end
          end else begin
            reads_acc++;
            rd_addr_q.push_back(f_addr);
            data_i = src_word(f_addr);
          end
          rsp_valid_i = 1'b1;
        end
        if (req_valid_o && !we_o && reads_acc == stall_read && stall_left > 0) begin
          if (stall_left == 3) begin
            s_addr = addr_o; s_data = data_o; s_sel = sel_o; s_we = we_o;
          end else begin
            tests++;
            if ({addr_o, data_o, sel_o, we_o} !== {s_addr, s_data, s_sel, s_we}) begin
              fails++;
              $display("FAIL stall_stable: got %h/%h/%h/%b, required %h/%h/%h/%b",
                       addr_o, data_o, sel_o, we_o, s_addr, s_data, s_sel, s_we);
            end
          end
          req_ready_i = 1'b0;
          stall_left--;
          stall_seen++;
        end else begin
          req_ready_i = 1'b1;
        end
        req_f  = req_valid_o && req_ready_i;
        f_addr = addr_o; f_data = data_o; f_we = we_o;
        rsp_f  = rsp_valid_i && rsp_ready_o;
      end
      if (req_valid_o) req_cycles++;
      if (busy_o) busy_cycles++;
      if (done_o) done_cycles++;
    end
  end

  task automatic clear_counters();
    req_fire_cnt = 0; req_cycles = 0; busy_cycles = 0; done_cycles = 0;
    wr_count = 0; reads_acc = 0; stall_seen = 0;
    rd_addr_q.delete(); we_log.delete();
  endtask

  // Called at a falling edge; returns at the next falling edge with start low.
  task automatic do_start(input logic [31:0] s, input logic [31:0] d,
                          input logic [15:0] n, output int unsigned t0);
    logic [31:0] sa, da;
    wr_t e;
    sa = {s[31:2], 2'b00};
    da = {d[31:2], 2'b00};
    for (int unsigned i = 0; i < n; i++) begin
      e.addr = da + 32'(4 * i);
      e.data = src_word(sa + 32'(4 * i));
      exp_q.push_back(e);
    end
    src_addr_i = s; dst_addr_i = d; len_i = n; start_i = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int unsigned lat, output logic ok);
    ok = 1'b0;
    lat = 0;
    for (int i = 0; i < budget; i++) begin
      if (done_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_lat(input string name, input int unsigned t0, input logic ok,
                           input int unsigned want);
    int unsigned lat;
    lat = cyc - t0;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s_timeout: done_o not seen, required latency %0d", name, want);
    end else if (lat != want) begin
      fails++;
      $display("FAIL %s_latency: got %0d cycles, required %0d", name, lat, want);
    end
  endtask

  task automatic check_mem(input string name, input logic [31:0] s, input logic [31:0] d,
                           input int unsigned n);
    logic [31:0] got, want;
    for (int unsigned i = 0; i < n; i++) begin
      want = src_word(s + 32'(4 * i));
      got  = mem.exists(d + 32'(4 * i)) ? mem[d + 32'(4 * i)] : 32'hXXXX_XXXX;
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL %s_mem[%0d]: got %h, required %h", name, i, got, want);
      end
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_sb_left: got %0d pending writes, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; src_addr_i = '0; dst_addr_i = '0; len_i = '0;
    repeat (2) @(negedge clk);
    tests++;
    if ({busy_o, done_o, irq_o, addr_o, data_o, sel_o, we_o, req_valid_o, rsp_ready_o} !== 74'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h, required 0",
               {busy_o, done_o, irq_o, addr_o, data_o, sel_o, we_o, req_valid_o, rsp_ready_o});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_copy4();
    int unsigned t0, lat;
    logic ok;
    clear_counters();
    do_start(32'h0000_0100, 32'h0000_0200, 16'd4, t0);
    wait_done(40, lat, ok);
    check_lat("copy4", t0, ok, 17);
    check_mem("copy4", 32'h0000_0100, 32'h0000_0200, 4);
    tests++;
    if (req_fire_cnt != 8) begin
      fails++;
      $display("FAIL copy4_req_count: got %0d, required 8", req_fire_cnt);
    end
    for (int i = 0; i < we_log.size(); i++) begin
      tests++;
      if (we_log[i] !== logic'(i % 2)) begin
        fails++;
        $display("FAIL copy4_we_order[%0d]: got %b, required %0d", i, we_log[i], i % 2);
      end
    end
    @(negedge clk);
    tests++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      fails++;
      $display("FAIL copy4_after_done: got done=%b busy=%b, required 0/0", done_o, busy_o);
    end
  endtask

  task automatic test_len_zero();
    int unsigned t0, lat;
    logic ok;
    clear_counters();
    do_start(32'h0000_0400, 32'h0000_0500, 16'd0, t0);
    wait_done(10, lat, ok);
    check_lat("len0", t0, ok, 1);
    @(negedge clk);
    tests++;
    if (req_cycles != 0 || busy_cycles != 1) begin
      fails++;
      $display("FAIL len0_traffic: got req_cycles=%0d busy_cycles=%0d, required 0/1",
               req_cycles, busy_cycles);
    end
  endtask

  task automatic test_stall();
    int unsigned t0, lat;
    logic ok;
    clear_counters();
    stall_read = 1; stall_left = 3;
    do_start(32'h0000_0600, 32'h0000_0700, 16'd3, t0);
    wait_done(40, lat, ok);
    check_lat("stall", t0, ok, 16);
    check_mem("stall", 32'h0000_0600, 32'h0000_0700, 3);
    tests++;
    if (stall_seen != 3) begin
      fails++;
      $display("FAIL stall_cycles: got %0d, required 3", stall_seen);
    end
    stall_read = -1;
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int unsigned t0, lat;
    int d0;
    logic ok, hit;
    clear_counters();
    do_start(32'h0000_1000, 32'h0000_2000, 16'd5, t0);
    hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (req_valid_o && we_o && wr_count == 1) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL abort_reach_wr2: got no second write request, required one");
    end
    d0 = done_cycles;
    rst = 1'b1;
    #1;
    tests++;
    if ({busy_o, done_o, irq_o, addr_o, data_o, sel_o, we_o, req_valid_o, rsp_ready_o} !== 74'd0) begin
      fails++;
      $display("FAIL abort_outputs: got %h, required 0",
               {busy_o, done_o, irq_o, addr_o, data_o, sel_o, we_o, req_valid_o, rsp_ready_o});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    tests++;
    if (done_cycles != d0) begin
      fails++;
      $display("FAIL abort_no_done: got %0d done cycles, required 0", done_cycles - d0);
    end
    clear_counters();
    do_start(32'h0000_1100, 32'h0000_2100, 16'd3, t0);
    wait_done(40, lat, ok);
    check_lat("after_abort", t0, ok, 13);
    check_mem("after_abort", 32'h0000_1100, 32'h0000_2100, 3);
    @(negedge clk);
  endtask

  task automatic test_wrap_and_busy_start();
    int unsigned t0, lat;
    logic ok;
    clear_counters();
    do_start(32'hFFFF_FFFC, 32'h0000_3000, 16'd2, t0);
    @(negedge clk);
    src_addr_i = 32'h0000_5000; dst_addr_i = 32'h0000_6000; len_i = 16'd7; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_done(40, lat, ok);
    check_lat("wrap", t0, ok, 9);
    check_mem("wrap", 32'hFFFF_FFFC, 32'h0000_3000, 2);
    tests++;
    if (rd_addr_q.size() != 2) begin
      fails++;
      $display("FAIL wrap_read_count: got %0d, required 2", rd_addr_q.size());
    end else if (rd_addr_q[1] !== 32'h0000_0000) begin
      fails++;
      $display("FAIL wrap_second_addr: got %h, required 00000000", rd_addr_q[1]);
    end
    repeat (2) @(negedge clk);
    tests++;
    if (busy_o !== 1'b0) begin
      fails++;
      $display("FAIL busy_start_ignored: got busy=%b, required 0", busy_o);
    end
  endtask

  task automatic test_irq();
    int unsigned t0, lat;
    logic ok;
    logic exp_irq;
`ifdef MEM_COPY_DMA_IRQ_EN
    exp_irq = 1'b1;
`else
    exp_irq = 1'b0;
`endif
    clear_counters();
    do_start(32'h0000_7000, 32'h0000_7100, 16'd1, t0);
    wait_done(20, lat, ok);
    check_lat("irq", t0, ok, 5);
    tests++;
    if (irq_o !== exp_irq) begin
      fails++;
      $display("FAIL irq_on_done: got %b, required %b", irq_o, exp_irq);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (irq_o !== exp_irq) begin
      fails++;
      $display("FAIL irq_sticky: got %b, required %b", irq_o, exp_irq);
    end
    do_start(32'h0000_7200, 32'h0000_7300, 16'd1, t0);
    tests++;
    if (irq_o !== 1'b0) begin
      fails++;
      $display("FAIL irq_clear_on_start: got %b, required 0", irq_o);
    end
    wait_done(20, lat, ok);
    check_lat("irq2", t0, ok, 5);
    check_mem("irq2", 32'h0000_7200, 32'h0000_7300, 1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_copy4();
    test_len_zero();
    test_stall();
    test_reset_abort();
    test_wrap_and_busy_start();
    test_irq();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
